// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: state encoding, instruction size, alignment helper.
package fetch_pkg;

  localparam int INST_BYTES = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of packed {pc, inst, fault} entries; registered head, no bypass.
// Flush empties the queue but still accepts a same-cycle push as the sole new entry.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = 2 * WIDTH + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [EW-1:0] push_entry,
  input  logic          pop,
  input  logic          flush,
  output logic [EW-1:0] head,
  output logic [AW:0]   count
);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_idx;

  assign wr_idx = flush ? '0 : wr_ptr;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? (AW+1)'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issue -> capture next cycle -> queue head the cycle after.
// Optional FETCH_PERF_CNT_EN adds saturating starvation / credit-block counters.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  output logic [WIDTH-1:0] inst_addr,
  input  logic [WIDTH-1:0] inst_data,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_starve_cnt,
  output logic [31:0]      perf_full_cnt
`endif
);
  import fetch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
    logic             fault;
  } fetch_entry_t;

  fetch_state_e     state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] inflight_pc;
  logic             inflight;
  logic [AW:0]      count;
  logic [AW+1:0]    pending;
  logic             pop;
  logic             credit_ok;
  logic             issue;
  logic             bad_target;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [EW-1:0]    push_bits;
  logic [EW-1:0]    head_bits;

  assign inst_addr  = fetch_pc;
  assign out_valid  = count != '0;
  assign pop        = out_valid && out_ready;
  assign bad_target = misaligned(redirect_pc[1:0]);

  // Slots already promised: queued entries plus the word still on its way, minus this cycle's pop.
  assign pending   = (AW+2)'(count) + (AW+2)'(inflight) - (AW+2)'(pop);
  assign credit_ok = pending < (AW+2)'(DEPTH);
  assign issue     = (state == RUN) && fetch_en && !redirect && credit_ok;

  always_comb begin
    push       = inflight;
    push_entry = '{pc: inflight_pc, inst: inst_data, fault: 1'b0};
    if (redirect) begin
      push       = bad_target;
      push_entry = '{pc: redirect_pc, inst: '0, fault: 1'b1};
    end
  end

  assign push_bits = push_entry;
  assign head      = fetch_entry_t'(head_bits);
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign out_fault = head.fault;

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_bits),
    .pop        (pop),
    .flush      (redirect),
    .head       (head_bits),
    .count      (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      inflight <= 1'b0;
      if (bad_target) begin
        state <= FAULT;
      end else begin
        state    <= RUN;
        fetch_pc <= redirect_pc;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + WIDTH'(INST_BYTES);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic starve;
  logic blocked;

  assign starve  = !out_valid && (state == RUN) && fetch_en;
  assign blocked = (state == RUN) && fetch_en && !redirect && !credit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_starve_cnt <= '0;
      perf_full_cnt   <= '0;
    end else begin
      if (starve && perf_starve_cnt != '1)  perf_starve_cnt <= perf_starve_cnt + 32'd1;
      if (blocked && perf_full_cnt != '1)   perf_full_cnt   <= perf_full_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle, directed scenarios, random traffic.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_starve_cnt;
  logic [31:0] perf_full_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_fault   (out_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_starve_cnt (perf_starve_cnt),
    .perf_full_cnt   (perf_full_cnt)
`endif
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  // Synchronous RAM port: word for last cycle's address.
  always @(posedge clk) inst_data <= ram_word(inst_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          fault;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_infl_pc;
  bit          m_infl;
  bit          m_fault;
  bit          m_known = 1'b0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int sz;
    bit pop;
    bit iss;
    if (rst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_infl  = 1'b0;
      m_fault = 1'b0;
      m_known = 1'b1;
      return;
    end
    sz  = mq.size();
    pop = (sz > 0) && out_ready;
    iss = !m_fault && fetch_en && !redirect && ((sz + int'(m_infl) - int'(pop)) < DEPTH);
    if (pop) void'(mq.pop_front());
    if (redirect) begin
      mq.delete();
      m_infl = 1'b0;
      if (redirect_pc[1:0] == 2'b00) begin
        m_pc    = redirect_pc;
        m_fault = 1'b0;
      end else begin
        mq.push_back('{redirect_pc, 32'h0, 1'b1});
        m_fault = 1'b1;
      end
    end else begin
      if (m_infl) mq.push_back('{m_infl_pc, ram_word(m_infl_pc), 1'b0});
      if (iss) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end
      m_infl = iss;
    end
  endtask

  // One clock: compare on the falling edge, advance model, return just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (m_known && !rst) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_inst", out_inst, mq[0].inst);
        chk("out_fault", 32'(out_fault), 32'(mq[0].fault));
      end
      if (!m_fault) chk("inst_addr", inst_addr, m_pc);
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] saved;
  int          r;

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state and first-fetch latency
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_addr", inst_addr, RESET_PC);
    step();
    chk("cyc1_valid", 32'(out_valid), 32'h0);
    step();
    chk("cyc2_valid", 32'(out_valid), 32'h1);
    chk("cyc2_pc", out_pc, 32'h0);
    chk("cyc2_inst", out_inst, 32'h100);
    step();
    chk("cyc3_pc", out_pc, 32'h4);
    chk("cyc3_inst", out_inst, 32'h101);
    repeat (4) step();

    // Backpressure: queue fills to DEPTH, fetch stops at 0x10
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("full_addr", inst_addr, 32'h10);
    chk("model_full", 32'(mq.size()), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      step();
    end

    // Redirect with three queued entries and one fetch in flight
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("model_q3", 32'(mq.size()), 32'd3);
    chk("model_infl", 32'(m_infl), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0; out_ready = 1'b1;
    chk("redir_r1", 32'(out_valid), 32'h0);
    step();
    chk("redir_r2", 32'(out_valid), 32'h0);
    step();
    chk("redir_r3_valid", 32'(out_valid), 32'h1);
    chk("redir_r3_pc", out_pc, 32'h40);
    chk("redir_r3_inst", out_inst, 32'h110);

    // Misaligned redirect -> single fault entry, then silence
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    chk("fault_valid", 32'(out_valid), 32'h1);
    chk("fault_flag", 32'(out_fault), 32'h1);
    chk("fault_pc", out_pc, 32'h42);
    chk("fault_inst", out_inst, 32'h0);
    step();
    repeat (5) begin
      chk("fault_quiet", 32'(out_valid), 32'h0);
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    step(); step();
    chk("resume_pc", out_pc, 32'h20);
    chk("resume_fault", 32'(out_fault), 32'h0);

    // Pause: inst_addr frozen, queue drains
    repeat (3) step();
    fetch_en = 1'b0;
    saved = inst_addr;
    repeat (5) begin
      step();
      chk("frozen_addr", inst_addr, saved);
    end
    chk("paused_empty", 32'(out_valid), 32'h0);
    fetch_en = 1'b1;
    repeat (6) step();

    // Address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step(); step();
    chk("wrap_top_pc", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero_pc", out_pc, 32'h0);
    chk("wrap_zero_inst", out_inst, 32'h100);

    // Redirect coincident with a pop
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0;
    chk("pop_redir_r1", 32'(out_valid), 32'h0);
    step();
    chk("pop_redir_r2", 32'(out_valid), 32'h0);
    step();
    chk("pop_redir_pc", out_pc, 32'h80);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      fetch_en  = ($urandom_range(0, 9) < 9);
      redirect  = ($urandom_range(0, 99) < 3);
      r = int'($urandom_range(0, 9));
      if (r == 0)      redirect_pc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else if (r == 1) redirect_pc = $urandom;
      else             redirect_pc = 32'($urandom_range(0, 255)) << 2;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; redirect = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the cust-risc core; directly upstream of the memory manager's instruction read port.
- Drives `inst_addr` and captures `inst_data`, which returns one cycle later from the synchronous RAM port B.
- Buffers fetched words with their PCs in a small prefetch queue and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects, including flushing in-flight fetches, and reports misaligned redirect targets.

Parameters:
- WIDTH, 32, data/address width in bits; matches mem_mgr WIDTH.
- RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.
- DEPTH, 4, prefetch queue entries; power of 2, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  allow issuing new fetches; low = pause (queue still drains).
- inst_addr  output  WIDTH  fetch address to mem_mgr port B.
- inst_data  input  WIDTH  word read from inst_addr of previous cycle.
- redirect  input  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  WIDTH  new fetch target, sampled when redirect=1.
- out_valid  output  1  queue head valid.
- out_ready  input  1  decode accepts head.
- out_inst  output  WIDTH  instruction at queue head.
- out_pc  output  WIDTH  PC of queue head.
- out_fault  output  1  head is an instruction-address-misaligned fault entry (out_inst = 0).

Behaviour:
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, queue empty, inflight=0, state=RUN.
- Reset values: out_valid=0, out_fault=0; out_inst/out_pc don't-care while out_valid=0. inst_addr=RESET_PC in the first cycle after reset.
- Reset mid-operation discards queue and in-flight fetch.
- inst_addr = fetch_pc (register, combinational out). The RAM reads every cycle; only issued reads are captured.
- Issue condition: state==RUN && fetch_en && !redirect && (count + inflight - pop) < DEPTH, where pop = out_valid && out_ready.
- On issue:
  - inflight<=1, inflight_pc<=fetch_pc.
  - fetch_pc<=fetch_pc+4, modulo 2^WIDTH; wraps from all-ones-minus-3 to 0 silently.
- Capture: if inflight=1 and no redirect this cycle, push {inflight_pc, inst_data, fault=0} at posedge.
- Latency: issue in cycle N -> queue write end of N+1 -> out_valid in N+2. Steady state: 1 instruction/cycle when out_ready held high.
- Queue: FIFO, output from head only, no bypass.
  - Simultaneous push+pop when full is legal; the credit check guarantees push never overflows.
  - Pop on empty is impossible (out_valid=0).
- Handshake: transfer when out_valid && out_ready; out_* stable while out_valid && !out_ready.
- Redirect (highest priority):
  - Any pop in the same cycle completes first, then the queue is cleared. The in-flight capture is dropped (inflight<=0). No issue that cycle.
  - redirect_pc[1:0]==0: fetch_pc<=redirect_pc, state<=RUN; first issue next cycle, out_valid two cycles after that.
  - redirect_pc[1:0]!=0: push single entry {pc=redirect_pc, inst=0, fault=1}, state<=FAULT.
- States:
  - RUN: normal fetching.
  - FAULT: no issue. Fault entry stays at head until popped, then the queue stays empty. Leave only via redirect (or rst).
  - fetch_en=0 in RUN: issue suppressed; an outstanding inflight is still captured; fetch_pc held.
- Redirect during FAULT behaves identically to redirect in RUN.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs `perf_starve_cnt` and `perf_full_cnt` (both 32 bits).
  - perf_starve_cnt increments each cycle with out_valid=0 && state==RUN && fetch_en.
  - perf_full_cnt increments each cycle issue is blocked by credits.
  - Both saturate at all-ones and are zeroed by rst.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package fetch_pkg:
  - INST_BYTES=4 constant.
  - fetch_state_e enum {RUN, FAULT}.
  - Parameterised fetch_entry_t struct {pc, inst, fault}; typedef is WIDTH-dependent via localparam in the module if needed.
- One sub-module: fetch_queue (synchronous FIFO of fetch_entry_t with push, pop, flush, count; DEPTH entries, pointer wrap by power-of-2 indexing).

Test Plan:
- Reset, RESET_PC=0, RAM words 0..7 = 0x100+i, out_ready=1 -> out_valid first in cycle 2 after reset; outputs pc 0,4,8,... with inst 0x100,0x101,... one per cycle.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 entries queued, inst_addr stops at 0x10, no drops; then out_ready=1 -> pcs 0,4,8,C,10 in order.
- Redirect to 0x40 while queue holds 3 entries and one fetch is in flight -> none of the old entries appear; next out_pc=0x40 three cycles after the redirect.
- Redirect to 0x42 -> single entry out_fault=1, out_pc=0x42, out_inst=0; no further out_valid until redirect to 0x20, which resumes at 0x20.
- fetch_en=0 for 5 cycles mid-stream -> queue drains, inst_addr frozen, resumes with consecutive pcs and no gaps or duplicates.
- fetch_pc=WIDTH'hFFFFFFFC -> next out_pc=0 (wrap); redirect coincident with pop: popped entry consumed, rest flushed.
